plus_dma_sequencer: RTL and testbench
=====================================

Name: plus_dma_sequencer

Overview:
- Plus-mode sound DMA sequencer: three channels fetch 16-bit instruction lists from RAM and play register writes into the YM2149 PSG, one instruction per channel per scanline.
- Sits beside the motherboard's memory and PSG paths.
- Arbitrates its own three channels onto a single memory read port and a single PSG write port.
- Issues per-channel interrupt flags to the CPU interrupt logic.

Parameters:
- NCH, 3, number of DMA channels (fixed at 3; the channel index is 2 bits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_strobe  in  1  one-cycle pulse at end of each HSYNC; starts a scheduling pass
- ch_enable  in  3  per-channel enable from ASIC DCSR
- cfg_we  in  1  load channel start address / prescaler
- cfg_sel  in  2  channel for cfg_we (3 = ignored)
- cfg_addr  in  16  list start address (bit0 ignored)
- cfg_prescale  in  8  pause prescaler for cfg_sel
- mem_req  out  1  instruction fetch request
- mem_addr  out  16  word address; bit0 always 0
- mem_ack  in  1  fetch complete; mem_data valid this cycle
- mem_data  in  16  instruction word
- psg_req  out  1  PSG register write request
- psg_reg  out  4  PSG register number
- psg_data  out  8  PSG data
- psg_ack  in  1  PSG write accepted
- irq_clr  in  3  per-channel interrupt clear
- irq_flags  out  3  sticky per-channel interrupt flags
- busy  out  1  pass in progress
- overrun  out  1  sticky: line_strobe dropped

Behaviour:
- Reset: all outputs 0. Per-channel addr, pause_cnt, pre_cnt, loop_cnt and loop_addr are 0. Pending flag cleared; active[2:0]=0.
- Reset mid-operation: mem_req/psg_req drop the next cycle; FSM returns to IDLE.
- FSM states: IDLE, SEL, FETCH, DECODE, PSGWR, NEXT.
- IDLE
  - Enter SEL on line_strobe or pending; set busy=1; channel index ch=0.
- SEL (one channel per visit)
  - If ch_enable[ch] & active[ch] & pause_cnt==0: go to FETCH.
  - Else, if pause_cnt!=0: prescale step. If pre_cnt==0, reload pre_cnt=prescale[ch] and decrement pause_cnt; otherwise decrement pre_cnt. Then go to NEXT.
  - Else: go to NEXT.
- FETCH
  - mem_req=1 with mem_addr=addr[ch]; hold until mem_ack.
  - Latch mem_data in the mem_ack cycle; go to DECODE.
  - Exactly one fetch per channel per pass.
- DECODE, by op=word[15:12]:
  - 0 LOAD: psg_reg=word[11:8], psg_data=word[7:0]; addr+=2; go to PSGWR.
  - 1 PAUSE n=word[11:0]: n=0 acts as NOP. Otherwise pause_cnt=n, pre_cnt=prescale[ch], addr+=2. The channel then skips exactly n*(prescale+1) passes.
  - 2 REPEAT n: loop_cnt=n, loop_addr=addr+2, addr+=2.
  - 4 CONTROL: bit4 (INT) sets irq_flags[ch]. bit0 (LOOP): if loop_cnt!=0, decrement loop_cnt and set addr=loop_addr; else addr+=2. bit5 (STOP) clears active[ch] and freezes addr; STOP overrides LOOP. No bits set: NOP.
  - Other ops: NOP, addr+=2.
  - Except after LOAD, go to NEXT.
- Looping: the REPEAT body executes n+1 times.
- PSGWR: psg_req=1 with reg/data stable until psg_ack; then go to NEXT.
- NEXT: if ch==2, go to IDLE with busy=0; else ch++ and go to SEL.
- Address arithmetic is 16-bit and wraps FFFE->0000.
- line_strobe while busy sets pending. If pending is already set, the strobe is dropped and overrun=1 (sticky until reset).
- cfg_we
  - Sets addr[cfg_sel]=cfg_addr&FFFE and prescale[cfg_sel]; clears pause_cnt, loop_cnt and pre_cnt; sets active.
  - If it hits the channel being executed, the cfg write wins and that instruction's addr/pause/loop updates are discarded. A LOAD already in PSGWR still completes.
- irq: a simultaneous set and irq_clr on the same bit resolves to set.
- ch_enable=0 freezes a channel entirely: no pause countdown, state retained.

Test Plan:
- Ch0 at 0x1000 = {0x0708, 0x4020}, prescale 0; two strobes. Required: pass 1 gives one PSG write reg7=0x08. Pass 2 fetches 0x1002 and sets active[0]=0. A third strobe gives no mem_req for ch0.
- PAUSE 3 with prescale 1. Required: the next 6 passes give no ch0 fetch; the 7th pass fetches addr+2.
- REPEAT 2, LOAD R0, 0x4011. Required: the LOAD executes 3 times; irq_flags[0] sets on each control fetch; list continues after the third pass. irq_clr with a same-cycle set keeps the flag at 1.
- All three channels enabled, mem_ack delayed 5 cycles and psg_ack delayed 3 cycles. Required: service order ch0, ch1, ch2; requests held stable until ack; busy drops after ch2.
- Two extra line_strobes during a busy pass. Required: one pass replays from pending, overrun=1. Then assert reset mid-FETCH: mem_req=0 the next cycle and all outputs are 0.
- Address 0xFFFE holding a NOP. Required: the next fetch is at 0x0000. cfg_we to ch1 during ch1 DECODE: the next fetch uses the new address.

Source files
------------

// File: rtl/plus_dma_sequencer.sv
// Plus-mode sound DMA sequencer: three instruction-list channels share one
// memory read port and one PSG write port, one instruction per channel per line.
module plus_dma_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_strobe,
  input  logic [2:0]  ch_enable,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_addr,
  input  logic [7:0]  cfg_prescale,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        psg_req,
  output logic [3:0]  psg_reg,
  output logic [7:0]  psg_data,
  input  logic        psg_ack,
  input  logic [2:0]  irq_clr,
  output logic [2:0]  irq_flags,
  output logic        busy,
  output logic        overrun
);

  localparam int NCH = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    FETCH,
    DECODE,
    PSGWR,
    NEXT
  } state_t;

  localparam logic [3:0] OP_LOAD    = 4'h0;
  localparam logic [3:0] OP_PAUSE   = 4'h1;
  localparam logic [3:0] OP_REPEAT  = 4'h2;
  localparam logic [3:0] OP_CONTROL = 4'h4;

  state_t      r_state;
  logic [1:0]  r_ch;
  logic        r_busy;
  logic        r_pending;
  logic        r_overrun;
  logic        r_mem_req;
  logic [15:0] r_mem_addr;
  logic        r_psg_req;
  logic [3:0]  r_psg_reg;
  logic [7:0]  r_psg_data;
  logic [2:0]  r_irq;
  logic [15:0] r_word;
  logic        r_cfg_hit;
  logic [2:0]  r_active;

  logic [15:0] r_addr      [NCH];
  logic [15:0] r_loop_addr [NCH];
  logic [11:0] r_pause_cnt [NCH];
  logic [11:0] r_loop_cnt  [NCH];
  logic [7:0]  r_pre_cnt   [NCH];
  logic [7:0]  r_prescale  [NCH];

  logic [3:0]  w_op;
  logic [11:0] w_arg;
  logic [15:0] w_addr_inc;
  logic        w_cfg_ok;
  logic        w_cfg_hit;
  logic        w_discard;
  logic [2:0]  w_irq_set;

  assign w_op       = r_word[15:12];
  assign w_arg      = r_word[11:0];
  assign w_addr_inc = r_addr[r_ch] + 16'd2;
  assign w_cfg_ok   = cfg_we && (cfg_sel != 2'd3);
  assign w_cfg_hit  = cfg_we && (cfg_sel == r_ch);
  // A config write that lands while this channel's instruction is in flight wins.
  assign w_discard  = r_cfg_hit || w_cfg_hit;
  assign w_irq_set  = (r_state == DECODE && w_op == OP_CONTROL && r_word[4])
                      ? (3'b001 << r_ch) : 3'b000;

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign psg_req   = r_psg_req;
  assign psg_reg   = r_psg_reg;
  assign psg_data  = r_psg_data;
  assign irq_flags = r_irq;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // NOTE: sequential state uses non-blocking assignments only, so every read below sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_busy     <= 1'b0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_psg_req  <= 1'b0;
      r_psg_reg  <= '0;
      r_psg_data <= '0;
      r_irq      <= '0;
      r_word     <= '0;
      r_cfg_hit  <= 1'b0;
      r_active   <= '0;
      // NOTE: the per-channel arrays are a few registers, not a RAM, so they are reset explicitly.
      for (int i = 0; i < NCH; i++) begin
        r_addr[i]      <= '0;
        r_loop_addr[i] <= '0;
        r_pause_cnt[i] <= '0;
        r_loop_cnt[i]  <= '0;
        r_pre_cnt[i]   <= '0;
        r_prescale[i]  <= '0;
      end
    end else begin
      r_irq <= (r_irq & ~irq_clr) | w_irq_set;

      if (r_busy && line_strobe) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (line_strobe || r_pending) begin
            r_state   <= SEL;
            r_busy    <= 1'b1;
            r_ch      <= '0;
            r_pending <= r_pending && line_strobe;
          end
        end

        SEL: begin
          if (!ch_enable[r_ch]) begin
            r_state <= NEXT;
          end else if (r_active[r_ch] && r_pause_cnt[r_ch] == '0) begin
            r_state    <= FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr[r_ch];
            r_cfg_hit  <= w_cfg_hit;
          end else begin
            if (r_pause_cnt[r_ch] != '0) begin
              if (r_pre_cnt[r_ch] == '0) begin
                r_pre_cnt[r_ch]   <= r_prescale[r_ch];
                r_pause_cnt[r_ch] <= r_pause_cnt[r_ch] - 12'd1;
              end else begin
                r_pre_cnt[r_ch] <= r_pre_cnt[r_ch] - 8'd1;
              end
            end
            r_state <= NEXT;
          end
        end

        FETCH: begin
          if (w_cfg_hit) r_cfg_hit <= 1'b1;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_word    <= mem_data;
            r_state   <= DECODE;
          end
        end

        DECODE: begin
          r_state <= NEXT;
          case (w_op)
            OP_LOAD: begin
              r_psg_reg  <= r_word[11:8];
              r_psg_data <= r_word[7:0];
              r_psg_req  <= 1'b1;
              r_state    <= PSGWR;
              if (!w_discard) r_addr[r_ch] <= w_addr_inc;
            end
            OP_PAUSE: begin
              if (!w_discard) begin
                r_addr[r_ch] <= w_addr_inc;
                if (w_arg != '0) begin
                  r_pause_cnt[r_ch] <= w_arg;
                  r_pre_cnt[r_ch]   <= r_prescale[r_ch];
                end
              end
            end
            OP_REPEAT: begin
              if (!w_discard) begin
                r_loop_cnt[r_ch]  <= w_arg;
                r_loop_addr[r_ch] <= w_addr_inc;
                r_addr[r_ch]      <= w_addr_inc;
              end
            end
            OP_CONTROL: begin
              if (!w_discard) begin
                if (r_word[5]) begin
                  r_active[r_ch] <= 1'b0;
                end else if (r_word[0] && r_loop_cnt[r_ch] != '0) begin
                  r_loop_cnt[r_ch] <= r_loop_cnt[r_ch] - 12'd1;
                  r_addr[r_ch]     <= r_loop_addr[r_ch];
                end else begin
                  r_addr[r_ch] <= w_addr_inc;
                end
              end
            end
            default: begin
              if (!w_discard) r_addr[r_ch] <= w_addr_inc;
            end
          endcase
        end

        PSGWR: begin
          if (psg_ack) begin
            r_psg_req <= 1'b0;
            r_state   <= NEXT;
          end
        end

        NEXT: begin
          if (r_ch == 2'd2) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ch    <= r_ch + 2'd1;
            r_state <= SEL;
          end
        end

        default: r_state <= IDLE;
      endcase

      // Placed last so a configuration write overrides any same-cycle channel update.
      if (w_cfg_ok) begin
        r_addr[cfg_sel]      <= cfg_addr & 16'hFFFE;
        r_prescale[cfg_sel]  <= cfg_prescale;
        r_pause_cnt[cfg_sel] <= '0;
        r_loop_cnt[cfg_sel]  <= '0;
        r_pre_cnt[cfg_sel]   <= '0;
        r_active[cfg_sel]    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plus_dma_sequencer.sv
// Self-checking bench for plus_dma_sequencer: memory/PSG responders compare every
// transaction against scoreboard queues filled as each pass is launched.
module tb_plus_dma_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_strobe;
  logic [2:0]  ch_enable;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_prescale;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        psg_req;
  logic [3:0]  psg_reg;
  logic [7:0]  psg_data;
  logic        psg_ack;
  logic [2:0]  irq_clr;
  logic [2:0]  irq_flags;
  logic        busy;
  logic        overrun;

  plus_dma_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .line_strobe  (line_strobe),
    .ch_enable    (ch_enable),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_prescale (cfg_prescale),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .psg_req      (psg_req),
    .psg_reg      (psg_reg),
    .psg_data     (psg_data),
    .psg_ack      (psg_ack),
    .irq_clr      (irq_clr),
    .irq_flags    (irq_flags),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 0;
  int psg_lat  = 0;

  logic [15:0] ram [0:32767];
  logic [15:0] exp_fetch [$];
  logic [11:0] exp_psg   [$];

  typedef struct {
    logic [15:0] word;
    logic        psg_v;
    logic [11:0] psg;
    logic        next_v;
    logic        irq;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, required no transaction", name, act);
  endtask

  // Memory responder: acks each fetch after mem_lat cycles and scores the address.
  initial begin
    logic [15:0] a;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1 && !reset) begin
        a = mem_addr;
        for (int k = 0; k < mem_lat; k++) begin
          @(negedge clk);
          if (!mem_req || reset) break;
        end
        if (mem_req && !reset) begin
          check("mem_addr_stable", mem_addr, a);
          if (exp_fetch.size() == 0) unexpected("fetch_unexpected", a);
          else check("fetch_addr", a, exp_fetch.pop_front());
          mem_data = ram[a[15:1]];
          mem_ack  = 1'b1;
        end
      end
    end
  end

  // PSG responder: acks each write after psg_lat cycles and scores {reg,data}.
  initial begin
    logic [11:0] w;
    psg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (psg_ack) begin
        psg_ack = 1'b0;
      end else if (psg_req === 1'b1 && !reset) begin
        w = {psg_reg, psg_data};
        for (int k = 0; k < psg_lat; k++) begin
          @(negedge clk);
          if (!psg_req || reset) break;
        end
        if (psg_req && !reset) begin
          check("psg_stable", {psg_reg, psg_data}, w);
          if (exp_psg.size() == 0) unexpected("psg_unexpected", w);
          else check("psg_write", w, exp_psg.pop_front());
          psg_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // NOTE: bench inputs change on the falling edge with blocking assignments, away from the DUT's sampling edge.
  task automatic cfg(input logic [1:0] sel, input logic [15:0] a, input logic [7:0] p);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_prescale = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_irq();
    @(negedge clk); irq_clr = 3'b111;
    @(negedge clk); irq_clr = 3'b000;
  endtask

  task automatic strobe();
    @(negedge clk); line_strobe = 1'b1;
    @(negedge clk); line_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_fetch_req(input logic [15:0] a, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1'b1);
  endtask

  task automatic run_pass(input string tag);
    strobe();
    check({tag, "_busy"}, busy, 1'b1);
    wait_idle({tag, "_done"});
    @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_fetch_q"}, exp_fetch.size(), 0);
    check({tag, "_psg_q"}, exp_psg.size(), 0);
  endtask

  initial begin
    vec_t        vecs [9];
    logic [15:0] base;

    vecs[0] = '{16'h0A5C, 1'b1, 12'hA5C, 1'b1, 1'b0};  // LOAD
    vecs[1] = '{16'h3FFF, 1'b0, 12'h000, 1'b1, 1'b0};  // unknown op -> NOP
    vecs[2] = '{16'h1000, 1'b0, 12'h000, 1'b1, 1'b0};  // PAUSE 0 -> NOP
    vecs[3] = '{16'h4010, 1'b0, 12'h000, 1'b1, 1'b1};  // CONTROL INT
    vecs[4] = '{16'h4000, 1'b0, 12'h000, 1'b1, 1'b0};  // CONTROL no bits
    vecs[5] = '{16'h4001, 1'b0, 12'h000, 1'b1, 1'b0};  // LOOP with loop_cnt 0
    vecs[6] = '{16'h4031, 1'b0, 12'h000, 1'b0, 1'b1};  // STOP beats LOOP, INT
    vecs[7] = '{16'hFFFF, 1'b0, 12'h000, 1'b1, 1'b0};  // op F -> NOP
    vecs[8] = '{16'h0F00, 1'b1, 12'hF00, 1'b1, 1'b0};  // LOAD reg F

    for (int i = 0; i < 32768; i++) ram[i] = 16'h4020;
    reset = 1'b1; line_strobe = 1'b0; ch_enable = 3'b001; cfg_we = 1'b0;
    cfg_sel = '0; cfg_addr = '0; cfg_prescale = '0; irq_clr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {mem_req, mem_addr, psg_req, psg_reg, psg_data, irq_flags, busy, overrun}, 64'd0);

    // LOAD then STOP; a third pass must not touch ch0.
    ram[16'h1000 >> 1] = 16'h0708;
    ram[16'h1002 >> 1] = 16'h4020;
    cfg(2'd0, 16'h1000, 8'd0);
    exp_fetch.push_back(16'h1000); exp_psg.push_back(12'h708);
    run_pass("t1_p1");
    exp_fetch.push_back(16'h1002);
    run_pass("t1_p2");
    run_pass("t1_p3");
    check_drained("t1");

    // PAUSE 3 with prescale 1 skips 6 passes.
    ram[16'h1100 >> 1] = 16'h1003;
    cfg(2'd0, 16'h1100, 8'd1);
    exp_fetch.push_back(16'h1100);
    run_pass("t2_pause");
    for (int p = 0; p < 6; p++) run_pass($sformatf("t2_skip%0d", p));
    check("t2_skip_fetch_q", exp_fetch.size(), 0);
    exp_fetch.push_back(16'h1102);
    run_pass("t2_resume");
    check_drained("t2");

    // REPEAT 2 / LOAD R0 / CONTROL INT|LOOP: body runs three times.
    ram[16'h1200 >> 1] = 16'h2002;
    ram[16'h1202 >> 1] = 16'h0011;
    ram[16'h1204 >> 1] = 16'h4011;
    cfg(2'd0, 16'h1200, 8'd0);
    clear_irq();
    exp_fetch.push_back(16'h1200);
    run_pass("t3_repeat");
    for (int rep = 0; rep < 3; rep++) begin
      exp_fetch.push_back(16'h1202); exp_psg.push_back(12'h011);
      run_pass($sformatf("t3_load%0d", rep));
      exp_fetch.push_back(16'h1204);
      if (rep == 1) begin
        strobe();
        wait_fetch_req(16'h1204, "t3_ctrl_fetch");
        @(negedge clk); irq_clr = 3'b001;
        @(negedge clk); irq_clr = 3'b000;
        check("t3_irq_set_over_clr", irq_flags[0], 1'b1);
        wait_idle("t3_ctrl_done");
        @(negedge clk);
        clear_irq();
        check("t3_irq_cleared", irq_flags[0], 1'b0);
      end else begin
        run_pass($sformatf("t3_ctrl%0d", rep));
        check($sformatf("t3_irq%0d", rep), irq_flags[0], 1'b1);
      end
    end
    exp_fetch.push_back(16'h1206);
    run_pass("t3_after");
    check_drained("t3");

    // Single-instruction vectors on ch0.
    for (int i = 0; i < 9; i++) begin
      base = 16'h2000 + 16'(i * 16);
      ram[base[15:1]]         = vecs[i].word;
      ram[base[15:1] + 15'd1] = 16'h4020;
      cfg(2'd0, base, 8'd0);
      clear_irq();
      exp_fetch.push_back(base);
      if (vecs[i].psg_v) exp_psg.push_back(vecs[i].psg);
      run_pass($sformatf("vec%0d_p1", i));
      check($sformatf("vec%0d_irq", i), irq_flags[0], vecs[i].irq);
      if (vecs[i].next_v) exp_fetch.push_back(base + 16'd2);
      run_pass($sformatf("vec%0d_p2", i));
      check_drained($sformatf("vec%0d", i));
    end

    // Three channels, slow memory and PSG: strict ch0, ch1, ch2 order.
    ram[16'h3000 >> 1] = 16'h0111;
    ram[16'h3100 >> 1] = 16'h0222;
    ram[16'h3200 >> 1] = 16'h0333;
    cfg(2'd0, 16'h3000, 8'd0);
    cfg(2'd1, 16'h3100, 8'd0);
    cfg(2'd2, 16'h3200, 8'd0);
    ch_enable = 3'b111; mem_lat = 5; psg_lat = 3;
    exp_fetch.push_back(16'h3000); exp_psg.push_back(12'h111);
    exp_fetch.push_back(16'h3100); exp_psg.push_back(12'h222);
    exp_fetch.push_back(16'h3200); exp_psg.push_back(12'h333);
    run_pass("t4_all");
    check_drained("t4");
    ch_enable = 3'b001; psg_lat = 0;

    // Strobes during a busy pass: one replay, then overrun.
    ram[16'h3300 >> 1] = 16'h3000;
    ram[16'h3302 >> 1] = 16'h3000;
    cfg(2'd0, 16'h3300, 8'd0);
    exp_fetch.push_back(16'h3300);
    exp_fetch.push_back(16'h3302);
    strobe();
    strobe();
    check("t5_overrun_after_one_extra", overrun, 1'b0);
    strobe();
    repeat (120) @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_overrun", overrun, 1'b1);
    check_drained("t5");

    // Reset while a fetch is outstanding.
    mem_lat = 20;
    strobe();
    wait_fetch_req(16'h3304, "t5_reset_fetch");
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_mem_req", mem_req, 1'b0);
    check("t5_reset_outputs", {mem_req, mem_addr, psg_req, psg_reg, psg_data, irq_flags, busy, overrun}, 64'd0);
    @(negedge clk);
    reset = 1'b0; mem_lat = 0;
    @(negedge clk);

    // Address wrap FFFE -> 0000.
    ram[16'hFFFE >> 1] = 16'h3000;
    ram[0]             = 16'h4020;
    cfg(2'd0, 16'hFFFE, 8'd0);
    exp_fetch.push_back(16'hFFFE);
    run_pass("t6_wrap_p1");
    exp_fetch.push_back(16'h0000);
    run_pass("t6_wrap_p2");
    check_drained("t6");

    // Config write to ch1 while ch1 decodes: new address wins.
    ch_enable = 3'b010;
    ram[16'h4000 >> 1] = 16'h3000;
    ram[16'h5000 >> 1] = 16'h4020;
    cfg(2'd1, 16'h4000, 8'd0);
    exp_fetch.push_back(16'h4000);
    strobe();
    wait_fetch_req(16'h4000, "t7_fetch");
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 16'h5001; cfg_prescale = 8'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_idle("t7_pass_done");
    @(negedge clk);
    exp_fetch.push_back(16'h5000);
    run_pass("t7_newaddr");
    check_drained("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
